// File: rtl/asym_fifo_narrow_to_wide_if.sv
// Narrow-in / wide-out handshake bundle for the packing FIFO.
// master drives the narrow stream and consumes wide words; slave is the FIFO.
interface asym_fifo_narrow_to_wide_if #(
  parameter int WIDTHN     = 4,
  parameter int RATIO      = 4,
  parameter int DEPTHW     = 8,
  parameter int ADDRWIDTHW = 3
);
  localparam int WIDTHW = WIDTHN * RATIO;

  logic                  in_valid;
  logic                  in_ready;
  logic [WIDTHN-1:0]     in_data;
  logic                  flush;
  logic                  out_valid;
  logic                  out_ready;
  logic [WIDTHW-1:0]     out_data;
  logic [ADDRWIDTHW:0]   level;

  modport master (
    output in_valid, in_data, flush, out_ready,
    input  in_ready, out_valid, out_data, level
  );

  modport slave (
    input  in_valid, in_data, flush, out_ready,
    output in_ready, out_valid, out_data, level
  );
endinterface

// File: rtl/asym_fifo_narrow_to_wide.sv
// Single-clock FIFO packing RATIO narrow words (LSB-first) into wide words.
// Narrow-write / wide-read RAM with a registered head word on the output.
module asym_fifo_narrow_to_wide #(
  parameter int WIDTHN     = 4,
  parameter int RATIO      = 4,
  parameter int DEPTHW     = 8,
  parameter int ADDRWIDTHW = 3
) (
  input  logic clk,
  input  logic rst,
  asym_fifo_narrow_to_wide_if.slave bus
);
  localparam int WIDTHW = WIDTHN * RATIO;
  localparam int SLOTW  = $clog2(RATIO);
  localparam int PTRW   = ADDRWIDTHW + SLOTW;
  localparam logic [ADDRWIDTHW:0] FULLLVL = (ADDRWIDTHW+1)'(DEPTHW);
  localparam logic [SLOTW-1:0]    LASTSLOT = SLOTW'(RATIO - 1);

  logic [WIDTHW-1:0] mem [DEPTHW];

  logic [PTRW-1:0]       wrPtr;
  logic [ADDRWIDTHW-1:0] rdPtr;
  logic [ADDRWIDTHW-1:0] rdPtrNext;
  logic [ADDRWIDTHW-1:0] wrEntry;
  logic [SLOTW-1:0]      wrSlot;
  logic [ADDRWIDTHW:0]   lvl;
  logic [ADDRWIDTHW:0]   lvlNext;
  logic [ADDRWIDTHW:0]   lvlAvail;
  logic                  inReadyQ;
  logic                  outValidQ;
  logic [WIDTHW-1:0]     outDataQ;
  logic [WIDTHW-1:0]     headWord;
  logic                  push;
  logic                  pop;
  logic                  complete;

  assign wrEntry = wrPtr[PTRW-1:SLOTW];
  assign wrSlot  = wrPtr[SLOTW-1:0];

  always_comb begin
    push      = bus.in_valid && inReadyQ;
    pop       = outValidQ && bus.out_ready;
    complete  = push && (wrSlot == LASTSLOT);
    lvlNext   = lvl + (ADDRWIDTHW+1)'(complete)
                    - (ADDRWIDTHW+1)'(pop);
    // Words completed this edge only become visible one cycle later.
    lvlAvail  = lvl - (ADDRWIDTHW+1)'(pop);
    rdPtrNext = rdPtr + ADDRWIDTHW'(pop);
    headWord  = mem[rdPtrNext];
    if (push && wrEntry == rdPtrNext)
      headWord[wrSlot*WIDTHN +: WIDTHN] = bus.in_data;
  end

  always_ff @(posedge clk) begin
    if (push && !bus.flush && !rst)
      mem[wrEntry][wrSlot*WIDTHN +: WIDTHN] <= bus.in_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wrPtr     <= '0;
      rdPtr     <= '0;
      lvl       <= '0;
      inReadyQ  <= 1'b1;
      outValidQ <= 1'b0;
      outDataQ  <= '0;
    end else if (bus.flush) begin
      wrPtr     <= '0;
      rdPtr     <= '0;
      lvl       <= '0;
      inReadyQ  <= 1'b1;
      outValidQ <= 1'b0;
    end else begin
      wrPtr     <= wrPtr + PTRW'(push);
      rdPtr     <= rdPtrNext;
      lvl       <= lvlNext;
      inReadyQ  <= lvlNext < FULLLVL;
      outValidQ <= lvlAvail != '0;
      outDataQ  <= headWord;
    end
  end

  assign bus.in_ready  = inReadyQ;
  assign bus.out_valid = outValidQ;
  assign bus.out_data  = outDataQ;
  assign bus.level     = lvl;
endmodule

// File: tb/tb_asym_fifo_narrow_to_wide.sv
// Bench for asym_fifo_narrow_to_wide: directed scenarios plus random
// traffic, all checked against a nibble-queue reference model.
module tb_asym_fifo_narrow_to_wide;
  localparam int WN = 4;
  localparam int RT = 4;
  localparam int DW = 8;
  localparam int AW = 3;
  localparam int CAP = DW * RT;

  logic clk = 0;
  logic rst = 0;
  always #5 clk = ~clk;

  asym_fifo_narrow_to_wide_if #(
    .WIDTHN(WN), .RATIO(RT), .DEPTHW(DW), .ADDRWIDTHW(AW)
  ) bus ();

  asym_fifo_narrow_to_wide #(
    .WIDTHN(WN), .RATIO(RT), .DEPTHW(DW), .ADDRWIDTHW(AW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int checks = 0;
  int errors = 0;
  int nq[$];
  int stall = 0;
  int acceptCnt = 0;
  int popCnt = 0;
  bit lastPush;

  function automatic int words();
    return nq.size() / RT;
  endfunction

  function automatic logic [WN*RT-1:0] headModel();
    logic [WN*RT-1:0] w;
    w = '0;
    for (int i = 0; i < RT; i++)
      w[i*WN +: WN] = WN'(nq[i]);
    return w;
  endfunction

  task automatic idleIn();
    bus.in_valid  = 0;
    bus.in_data   = '0;
    bus.flush     = 0;
    bus.out_ready = 0;
  endtask

  // One clock: check DUT against model, then advance model with what fired.
  task automatic cyc();
    bit push, pop;
    @(negedge clk);
    checks++;
    if (bus.level !== (AW+1)'(words())) begin
      errors++;
      $display("FAIL level: got %0d want %0d", bus.level, words());
    end
    checks++;
    if (bus.in_ready !== (nq.size() < CAP)) begin
      errors++;
      $display("FAIL in_ready: got %b want %b",
               bus.in_ready, nq.size() < CAP);
    end
    if (bus.out_valid === 1'b1) begin
      checks++;
      if (words() < 1) begin
        errors++;
        $display("FAIL valid_empty: out_valid=1 model words=0");
      end else if (bus.out_data !== headModel()) begin
        errors++;
        $display("FAIL out_data: got %h want %h",
                 bus.out_data, headModel());
      end
    end
    if (words() >= 1 && bus.out_valid !== 1'b1) stall++;
    else stall = 0;
    checks++;
    if (stall > 1) begin
      errors++;
      $display("FAIL bubble: out_valid low %0d cycles, want <=1", stall);
    end
    push = bus.in_valid && bus.in_ready;
    pop  = bus.out_valid && bus.out_ready;
    @(posedge clk);
    lastPush = 0;
    if (rst || bus.flush) begin
      nq.delete();
      stall = 0;
    end else begin
      if (pop) begin
        for (int i = 0; i < RT; i++) void'(nq.pop_front());
        popCnt++;
      end
      if (push) begin
        nq.push_back(int'(bus.in_data));
        acceptCnt++;
        lastPush = 1;
      end
    end
    #1;
  endtask

  task automatic pushWord(input logic [WN-1:0] d);
    bus.in_valid = 1;
    bus.in_data  = d;
    cyc();
    bus.in_valid = 0;
  endtask

  task automatic drain();
    int n = 0;
    idleIn();
    bus.out_ready = 1;
    while (nq.size() >= RT && n < 100) begin
      cyc();
      n++;
    end
    bus.out_ready = 0;
    checks++;
    if (nq.size() >= RT) begin
      errors++;
      $display("FAIL drain: %0d nibbles left want <%0d", nq.size(), RT);
    end
  endtask

  task automatic checkCleared(input string tag);
    checks++;
    if (bus.level !== '0 || bus.out_valid !== 1'b0 ||
        bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s: level=%0d out_valid=%b in_ready=%b want 0/0/1",
               tag, bus.level, bus.out_valid, bus.in_ready);
    end
  endtask

  task automatic test_reset();
    idleIn();
    rst = 1;
    @(posedge clk);
    #1;
    rst = 0;
    nq.delete();
    stall = 0;
    checkCleared("reset");
    checks++;
    if (bus.out_data !== '0) begin
      errors++;
      $display("FAIL reset_data: got %h want 0", bus.out_data);
    end
  endtask

  task automatic test_basic();
    for (int i = 1; i <= 4; i++) pushWord(WN'(i));
    checks++;
    if (bus.level !== 1 || bus.out_valid !== 0) begin
      errors++;
      $display("FAIL basic_complete: level=%0d valid=%b want 1/0",
               bus.level, bus.out_valid);
    end
    cyc();
    checks++;
    if (bus.out_valid !== 1 || bus.out_data !== 16'h4321) begin
      errors++;
      $display("FAIL basic_data: valid=%b data=%h want 1/4321",
               bus.out_valid, bus.out_data);
    end
    drain();
  endtask

  task automatic test_fill();
    int acc0;
    for (int i = 0; i < CAP; i++) pushWord(WN'($urandom));
    checks++;
    if (bus.in_ready !== 0 || bus.level !== 4'(DW)) begin
      errors++;
      $display("FAIL fill_full: in_ready=%b level=%0d want 0/%0d",
               bus.in_ready, bus.level, DW);
    end
    acc0 = acceptCnt;
    pushWord(WN'($urandom));
    checks++;
    if (acceptCnt !== acc0) begin
      errors++;
      $display("FAIL fill_overflow: accepted %0d want 0",
               acceptCnt - acc0);
    end
    bus.out_ready = 1;
    cyc();
    bus.out_ready = 0;
    checks++;
    if (bus.in_ready !== 1) begin
      errors++;
      $display("FAIL fill_pop_ready: got %b want 1", bus.in_ready);
    end
    acc0 = acceptCnt;
    bus.in_valid = 1;
    for (int i = 0; i < 8; i++) begin
      bus.in_data = WN'($urandom);
      cyc();
    end
    bus.in_valid = 0;
    checks++;
    if (acceptCnt - acc0 !== RT) begin
      errors++;
      $display("FAIL fill_refill: accepted %0d want %0d",
               acceptCnt - acc0, RT);
    end
    drain();
  endtask

  task automatic test_stream();
    int sent = 0;
    int n = 0;
    int pop0 = popCnt;
    idleIn();
    bus.out_ready = 1;
    while (sent < 100 && n < 400) begin
      bus.in_valid = 1;
      bus.in_data  = WN'(sent);
      cyc();
      if (lastPush) sent++;
      n++;
    end
    bus.in_valid = 0;
    n = 0;
    while ((nq.size() > 0 || bus.out_valid) && n < 20) begin
      cyc();
      n++;
    end
    bus.out_ready = 0;
    checks++;
    if (popCnt - pop0 !== 25 || nq.size() !== 0) begin
      errors++;
      $display("FAIL stream: words %0d left %0d want 25/0",
               popCnt - pop0, nq.size());
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] wantLvl [4];
    logic       wantVal [4];
    wantLvl = '{4'd3, 4'd2, 4'd1, 4'd0};
    wantVal = '{1'b1, 1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 3 * RT; i++) pushWord(WN'($urandom));
    cyc();
    bus.out_ready = 1;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (bus.level !== wantLvl[i] || bus.out_valid !== wantVal[i]) begin
        errors++;
        $display("FAIL b2b[%0d]: level=%0d valid=%b want %0d/%b",
                 i, bus.level, bus.out_valid, wantLvl[i], wantVal[i]);
      end
      cyc();
    end
    bus.out_ready = 0;
  endtask

  task automatic test_flush();
    pushWord(4'h5);
    pushWord(4'h6);
    bus.flush    = 1;
    bus.in_valid = 1;
    bus.in_data  = 4'h7;
    cyc();
    idleIn();
    checkCleared("flush");
    pushWord(4'hA);
    pushWord(4'hB);
    pushWord(4'hC);
    pushWord(4'hD);
    cyc();
    checks++;
    if (bus.out_valid !== 1 || bus.out_data !== 16'hDCBA) begin
      errors++;
      $display("FAIL flush_data: valid=%b data=%h want 1/dcba",
               bus.out_valid, bus.out_data);
    end
    drain();
  endtask

  task automatic test_reset_mid();
    logic [15:0] w;
    for (int i = 0; i < 5 * RT + 2; i++) pushWord(WN'($urandom));
    rst = 1;
    bus.in_valid = 1;
    bus.out_ready = 1;
    cyc();
    rst = 0;
    idleIn();
    checkCleared("reset_mid");
    checks++;
    if (bus.out_data !== '0) begin
      errors++;
      $display("FAIL reset_mid_data: got %h want 0", bus.out_data);
    end
    w = 16'($urandom);
    for (int i = 0; i < RT; i++) pushWord(w[i*WN +: WN]);
    cyc();
    checks++;
    if (bus.out_valid !== 1 || bus.out_data !== w) begin
      errors++;
      $display("FAIL reset_mid_fresh: valid=%b data=%h want 1/%h",
               bus.out_valid, bus.out_data, w);
    end
    drain();
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      bus.in_valid  = ($urandom_range(0, 3) != 0);
      bus.in_data   = WN'($urandom);
      bus.out_ready = ($urandom_range(0, 2) == 0);
      bus.flush     = ($urandom_range(0, 79) == 0);
      cyc();
    end
    idleIn();
    drain();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_fill();
    test_stream();
    test_back_to_back();
    test_flush();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
